// File: rtl/popcount_pkg.sv
// -----------------------------------------------------------------------------
// popcount_pkg
// Shared definitions for the popcount31 vector generator.
// - N_IN / CW : default vector width and count width
// - vec_t / cnt_t : vector and count types at the default widths
// - gen_state_t : generator FSM states
// -----------------------------------------------------------------------------
package popcount_pkg;

    localparam int N_IN = 31;
    localparam int CW   = 5;

    typedef logic [N_IN-1:0] vec_t;
    typedef logic [CW-1:0]   cnt_t;

    typedef enum logic {
        IDLE = 1'b0,
        GEN  = 1'b1
    } gen_state_t;

endpackage : popcount_pkg

// File: rtl/popcount_rotl.sv
// -----------------------------------------------------------------------------
// popcount_rotl
// Combinational rotate-left of an N-bit vector by 0..N-1 positions. This works
// for any N, including widths that are not a power of two.
// Ports:
//   din_i  in  N   vector to rotate
//   amt_i  in  AW  rotate amount, must be < N
//   dout_o out N   din_i rotated left by amt_i
// -----------------------------------------------------------------------------
module popcount_rotl #(
    parameter int N  = 31,
    parameter int AW = 5
) (
    input  logic [N-1:0]  din_i,
    input  logic [AW-1:0] amt_i,
    output logic [N-1:0]  dout_o
);

    // Shifting the doubled vector left moves the bits that leave the top of
    // the original copy into the upper half, so the upper half is the rotation.
    logic [2*N-1:0] dbl;

    assign dbl    = {din_i, din_i} << amt_i;
    assign dout_o = dbl[2*N-1:N];

endmodule : popcount_rotl

// File: rtl/popcount31_vec_gen.sv
// -----------------------------------------------------------------------------
// popcount31_vec_gen
// Driving end of the 31-input popcount interface. It accepts a count K and
// emits a burst of NUM_VEC vectors. Each vector is a thermometer code of K ones
// rotated left by a running amount. K is forwarded as the golden count.
// Ports:
//   clk        in   1     clock, rising edge
//   rst_n      in   1     asynchronous active-low reset
//   cnt_valid  in   1     requested count present
//   cnt_ready  out  1     generator can accept a count (IDLE, not in reset)
//   cnt_k      in   CW    requested popcount K (saturated to N_IN)
//   vec_valid  out  1     vec_data / vec_count valid
//   vec_ready  in   1     consumer accepts the current vector
//   vec_data   out  N_IN  vector with exactly K ones
//   vec_count  out  CW    golden count for vec_data
//   vec_last   out  1     final vector of the burst
//   busy       out  1     burst in progress
// -----------------------------------------------------------------------------
module popcount31_vec_gen #(
    parameter int N_IN     = popcount_pkg::N_IN,
    parameter int CW       = popcount_pkg::CW,
    parameter int NUM_VEC  = 4,
    parameter int ROT_STEP = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cnt_valid,
    output logic            cnt_ready,
    input  logic [CW-1:0]   cnt_k,
    output logic            vec_valid,
    input  logic            vec_ready,
    output logic [N_IN-1:0] vec_data,
    output logic [CW-1:0]   vec_count,
    output logic            vec_last,
    output logic            busy
);

    import popcount_pkg::*;

    localparam int ROT_W = $clog2(N_IN);
    localparam int IDX_W = (NUM_VEC > 1) ? $clog2(NUM_VEC) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VEC - 1);

    gen_state_t        state_q, state_d;
    logic [CW-1:0]     k_q, k_d;
    logic [ROT_W-1:0]  rot_q, rot_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              vec_valid_q, vec_valid_d;
    logic [N_IN-1:0]   vec_data_q, vec_data_d;
    logic [CW-1:0]     vec_count_q, vec_count_d;
    logic              vec_last_q, vec_last_d;

    logic              load_vec;
    logic [CW-1:0]     k_sat;
    logic [ROT_W:0]    rot_sum;
    logic [ROT_W-1:0]  rot_wrap;
    logic [N_IN-1:0]   therm_d;
    logic [N_IN-1:0]   rot_vec;

    assign cnt_ready = (state_q == IDLE) && rst_n;
    assign busy      = (state_q == GEN);

    // The saturation is a no-op at the default widths. It only matters when
    // CW is widened beyond the range N_IN needs.
    assign k_sat = (int'(cnt_k) > N_IN) ? CW'(N_IN) : cnt_k;

    // The rotation wraps modulo N_IN, which is not a power of two. The sum is
    // computed one bit wider so that the compare sees the true value.
    assign rot_sum  = {1'b0, rot_q} + (ROT_W+1)'(ROT_STEP);
    assign rot_wrap = (rot_sum >= (ROT_W+1)'(N_IN)) ?
                      ROT_W'(rot_sum - (ROT_W+1)'(N_IN)) : rot_sum[ROT_W-1:0];

    // NOTE: every signal assigned in a combinational block gets a default
    // first. Without the defaults, a missed branch would infer a latch.
    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        rot_d       = rot_q;
        idx_d       = idx_q;
        vec_valid_d = vec_valid_q;
        vec_count_d = vec_count_q;
        vec_last_d  = vec_last_q;
        load_vec    = 1'b0;
        case (state_q)
            IDLE: begin
                if (cnt_valid && cnt_ready) begin
                    state_d     = GEN;
                    k_d         = k_sat;
                    rot_d       = '0;
                    idx_d       = '0;
                    vec_valid_d = 1'b1;
                    vec_count_d = k_sat;
                    vec_last_d  = (NUM_VEC == 1);
                    load_vec    = 1'b1;
                end
            end
            GEN: begin
                if (vec_ready) begin
                    if (vec_last_q) begin
                        state_d     = IDLE;
                        vec_valid_d = 1'b0;
                        vec_last_d  = 1'b0;
                    end else begin
                        idx_d      = idx_q + 1'b1;
                        rot_d      = rot_wrap;
                        vec_last_d = (idx_d == LAST_IDX);
                        load_vec   = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The next vector is built from the next-state K and rotation, so the
    // registered vec_data is ready in the cycle right after acceptance.
    always_comb begin
        therm_d = '0;
        for (int i = 0; i < N_IN; i++) begin
            therm_d[i] = (i < int'(k_d));
        end
    end

    popcount_rotl #(
        .N  (N_IN),
        .AW (ROT_W)
    ) u_rotl (
        .din_i  (therm_d),
        .amt_i  (rot_d),
        .dout_o (rot_vec)
    );

    // When a vector is not loaded, vec_data holds its value. This keeps the
    // output bit-stable during a stall.
    assign vec_data_d = load_vec ? rot_vec : vec_data_q;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            k_q         <= '0;
            rot_q       <= '0;
            idx_q       <= '0;
            vec_valid_q <= 1'b0;
            vec_data_q  <= '0;
            vec_count_q <= '0;
            vec_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            rot_q       <= rot_d;
            idx_q       <= idx_d;
            vec_valid_q <= vec_valid_d;
            vec_data_q  <= vec_data_d;
            vec_count_q <= vec_count_d;
            vec_last_q  <= vec_last_d;
        end
    end

    assign vec_valid = vec_valid_q;
    assign vec_data  = vec_data_q;
    assign vec_count = vec_count_q;
    assign vec_last  = vec_last_q;

endmodule : popcount31_vec_gen

// File: tb/tb_popcount31_vec_gen.sv
// -----------------------------------------------------------------------------
// tb_popcount31_vec_gen
// Scoreboard bench for the popcount31 vector generator. The stimulus pushes
// the expected vectors into a queue for each instance. A monitor per instance
// pops an entry and compares it on every vec handshake. Instance a uses
// NUM_VEC=4. Instance b uses NUM_VEC=32 so that the rotation crosses the
// modulo-31 wrap.
// -----------------------------------------------------------------------------
module tb_popcount31_vec_gen;

    typedef struct {
        logic [30:0] data;
        logic [4:0]  count;
        logic        last;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        cnt_valid, cnt_ready, vec_valid, vec_ready, vec_last, busy;
    logic [4:0]  cnt_k, vec_count;
    logic [30:0] vec_data;

    logic        cnt_valid_b, cnt_ready_b, vec_valid_b, vec_ready_b, vec_last_b, busy_b;
    logic [4:0]  cnt_k_b, vec_count_b;
    logic [30:0] vec_data_b;

    exp_t q0[$];
    exp_t q1[$];
    exp_t e0, e1;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int acc0      = 0;

    logic [30:0] snap_data;
    logic [4:0]  snap_count;
    logic        snap_last;
    int          acc_base;

    always #5 clk = ~clk;

    popcount31_vec_gen #(.NUM_VEC(4), .ROT_STEP(1)) dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .cnt_valid (cnt_valid),
        .cnt_ready (cnt_ready),
        .cnt_k     (cnt_k),
        .vec_valid (vec_valid),
        .vec_ready (vec_ready),
        .vec_data  (vec_data),
        .vec_count (vec_count),
        .vec_last  (vec_last),
        .busy      (busy)
    );

    popcount31_vec_gen #(.NUM_VEC(32), .ROT_STEP(1)) dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .cnt_valid (cnt_valid_b),
        .cnt_ready (cnt_ready_b),
        .cnt_k     (cnt_k_b),
        .vec_valid (vec_valid_b),
        .vec_ready (vec_ready_b),
        .vec_data  (vec_data_b),
        .vec_count (vec_count_b),
        .vec_last  (vec_last_b),
        .busy      (busy_b)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // The reference model sets bit (j+r) mod 31 for each j < k. It is used only
    // for the long instance-b burst. The values that matter there are also
    // written out as literals.
    function automatic logic [30:0] model_vec(input int k, input int r);
        logic [30:0] v;
        v = '0;
        for (int j = 0; j < k; j++) v[(j + r) % 31] = 1'b1;
        return v;
    endfunction

    task automatic push0(input logic [30:0] d, input logic [4:0] c, input logic l);
        exp_t e;
        e.data = d; e.count = c; e.last = l;
        q0.push_back(e);
    endtask

    task automatic push0_burst(input logic [30:0] v0, input logic [30:0] v1,
                               input logic [30:0] v2, input logic [30:0] v3,
                               input logic [4:0] c);
        push0(v0, c, 1'b0);
        push0(v1, c, 1'b0);
        push0(v2, c, 1'b0);
        push0(v3, c, 1'b1);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_a(input logic [4:0] k);
        cnt_valid = 1'b1;
        cnt_k     = k;
        tick();
        cnt_valid = 1'b0;
        check("accept_latency_valid", vec_valid, 1'b1);
    endtask

    task automatic wait_idle_a();
        for (int i = 0; i < 200; i++) begin
            if (!vec_valid && !busy) break;
            tick();
        end
        check("idle_a_timeout", {vec_valid, busy}, 2'b00);
    endtask

    task automatic wait_idle_b();
        for (int i = 0; i < 200; i++) begin
            if (!vec_valid_b && !busy_b) break;
            tick();
        end
        check("idle_b_timeout", {vec_valid_b, busy_b}, 2'b00);
    endtask

    // Monitors. Inputs change 1 time unit after the rising edge, so on the
    // falling edge a valid&&ready pair is exactly the next handshake.
    always @(negedge clk) begin
        if (rst_n && vec_valid && vec_ready) begin
            check("sb_a_expected", q0.size() != 0, 1'b1);
            if (q0.size() != 0) begin
                e0 = q0.pop_front();
                check("sb_a_data", vec_data, e0.data);
                check("sb_a_count", vec_count, e0.count);
                check("sb_a_last", vec_last, e0.last);
            end
            check("sb_a_popcount", $countones(vec_data), vec_count);
        end
        if (rst_n && cnt_valid && cnt_ready) acc0++;
    end

    always @(negedge clk) begin
        if (rst_n && vec_valid_b && vec_ready_b) begin
            check("sb_b_expected", q1.size() != 0, 1'b1);
            if (q1.size() != 0) begin
                e1 = q1.pop_front();
                check("sb_b_data", vec_data_b, e1.data);
                check("sb_b_count", vec_count_b, e1.count);
                check("sb_b_last", vec_last_b, e1.last);
            end
            check("sb_b_popcount", $countones(vec_data_b), vec_count_b);
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        exp_t eb;
        logic [30:0] v;
        rst_n       = 1'b0;
        cnt_valid   = 1'b0;
        cnt_k       = '0;
        vec_ready   = 1'b1;
        cnt_valid_b = 1'b0;
        cnt_k_b     = '0;
        vec_ready_b = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #3;
        check("rst_cnt_ready", cnt_ready, 1'b0);
        check("rst_vec_valid", vec_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_vec_data", vec_data, 31'h0);
        check("rst_vec_count", vec_count, 5'd0);
        check("rst_vec_last", vec_last, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("post_rst_cnt_ready", cnt_ready, 1'b1);

        // 1: K=5 basic burst
        push0_burst(31'h0000001F, 31'h0000003E, 31'h0000007C, 31'h000000F8, 5'd5);
        send_a(5'd5);
        wait_idle_a();
        check("t1_cnt_ready_after", cnt_ready, 1'b1);

        // 2: K=3 on the 32-vector instance, crossing the rot wrap
        for (int i = 0; i < 32; i++) begin
            if (i == 29)      v = 31'h60000001;
            else if (i == 30) v = 31'h40000003;
            else if (i == 31) v = 31'h00000007;
            else              v = model_vec(3, i);
            eb.data = v; eb.count = 5'd3; eb.last = (i == 31);
            q1.push_back(eb);
        end
        cnt_valid_b = 1'b1;
        cnt_k_b     = 5'd3;
        tick();
        cnt_valid_b = 1'b0;
        wait_idle_b();

        // 3: boundaries K=0 and K=31
        push0_burst(31'h0, 31'h0, 31'h0, 31'h0, 5'd0);
        send_a(5'd0);
        wait_idle_a();
        push0_burst(31'h7FFFFFFF, 31'h7FFFFFFF, 31'h7FFFFFFF, 31'h7FFFFFFF, 5'd31);
        send_a(5'd31);
        wait_idle_a();

        // 4: backpressure for 3 cycles mid-burst
        push0_burst(31'h000003FF, 31'h000007FE, 31'h00000FFC, 31'h00001FF8, 5'd10);
        send_a(5'd10);
        tick();
        vec_ready  = 1'b0;
        snap_data  = vec_data;
        snap_count = vec_count;
        snap_last  = vec_last;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t4_hold_data", vec_data, snap_data);
            check("t4_hold_count", vec_count, snap_count);
            check("t4_hold_last", vec_last, snap_last);
            check("t4_hold_valid", vec_valid, 1'b1);
        end
        vec_ready = 1'b1;
        wait_idle_a();

        // 5: cnt_valid held high across a burst
        push0_burst(31'h0000007F, 31'h000000FE, 31'h000001FC, 31'h000003F8, 5'd7);
        push0_burst(31'h000001FF, 31'h000003FE, 31'h000007FC, 31'h00000FF8, 5'd9);
        acc_base  = acc0;
        cnt_valid = 1'b1;
        cnt_k     = 5'd7;
        tick();
        check("t5_busy_first", busy, 1'b1);
        check("t5_ready_low", cnt_ready, 1'b0);
        cnt_k = 5'd9;
        for (int i = 0; i < 20; i++) begin
            if (!busy && cnt_ready) break;
            tick();
        end
        check("t5_idle_seen", {busy, cnt_ready}, 2'b01);
        tick();
        check("t5_busy_second", busy, 1'b1);
        check("t5_accepts_two", acc0 - acc_base, 2);
        cnt_valid = 1'b0;
        wait_idle_a();
        check("t5_accepts_final", acc0 - acc_base, 2);

        // 6: asynchronous reset mid-burst, then a fresh burst from rot 0
        push0_burst(31'h00000FFF, 31'h00001FFE, 31'h00003FFC, 31'h00007FF8, 5'd12);
        send_a(5'd12);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_valid", vec_valid, 1'b0);
        check("t6_rst_busy", busy, 1'b0);
        check("t6_rst_ready", cnt_ready, 1'b0);
        check("t6_abandoned", q0.size(), 3);
        q0.delete();
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        tick();
        push0_burst(31'h00000003, 31'h00000006, 31'h0000000C, 31'h00000018, 5'd2);
        send_a(5'd2);
        wait_idle_a();

        tick();
        check("final_q_a_empty", q0.size(), 0);
        check("final_q_b_empty", q1.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule : tb_popcount31_vec_gen
